// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and default width.
package serial_adder_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/serial_fa_cell.sv
// Combinational 1-bit full adder built from two half-adder stages and an OR.
module serial_fa_cell (
    input  logic i_a,
    input  logic i_b,
    input  logic i_cin,
    output logic o_s,
    output logic o_cout
);

    logic w_hs1_s;
    logic w_hs1_c;
    logic w_hs2_c;

    assign w_hs1_s = i_a ^ i_b;
    assign w_hs1_c = i_a & i_b;
    assign o_s     = w_hs1_s ^ i_cin;
    assign w_hs2_c = w_hs1_s & i_cin;
    assign o_cout  = w_hs1_c | w_hs2_c;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: operands accepted over valid/ready, summed LSB-first one bit
// per clock through a single full-adder cell, result presented over valid/ready.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             co
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_e           r_state;
    state_e           w_state_nxt;
    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic [WIDTH-1:0] r_sum_sh;
    logic [WIDTH-1:0] r_sum;
    logic [CNT_W-1:0] r_cnt;
    logic             r_carry;
    logic             r_co;
    logic             r_in_ready;
    logic             r_out_valid;

    logic             w_s_bit;
    logic             w_carry_nxt;
    logic             w_accept;
    logic             w_last;
    logic [WIDTH-1:0] w_sum_nxt;

    serial_fa_cell u_fa (
        .i_a    (r_a_sh[0]),
        .i_b    (r_b_sh[0]),
        .i_cin  (r_carry),
        .o_s    (w_s_bit),
        .o_cout (w_carry_nxt)
    );

    assign w_accept  = (r_state == ST_IDLE) && in_valid && r_in_ready;
    assign w_last    = (r_state == ST_RUN) && (r_cnt == CNT_W'(WIDTH - 1));
    assign w_sum_nxt = {w_s_bit, r_sum_sh[WIDTH-1:1]};

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode; the unused encoding falls back to IDLE
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_accept)  w_state_nxt = ST_RUN;
            ST_RUN:  if (w_last)    w_state_nxt = ST_DONE;
            ST_DONE: if (out_ready) w_state_nxt = ST_IDLE;
            default:                w_state_nxt = ST_IDLE;
        endcase
    end

    // Datapath and registered handshake outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a_sh      <= '0;
            r_b_sh      <= '0;
            r_sum_sh    <= '0;
            r_sum       <= '0;
            r_cnt       <= '0;
            r_carry     <= 1'b0;
            r_co        <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            r_in_ready  <= (w_state_nxt == ST_IDLE);
            r_out_valid <= (w_state_nxt == ST_DONE);
            if (w_accept) begin
                r_a_sh   <= a;
                r_b_sh   <= b;
                r_sum_sh <= '0;
                r_cnt    <= '0;
                r_carry  <= 1'b0;
            end else if (r_state == ST_RUN) begin
                r_a_sh   <= r_a_sh >> 1;
                r_b_sh   <= r_b_sh >> 1;
                r_sum_sh <= w_sum_nxt;
                r_cnt    <= r_cnt + CNT_W'(1);
                r_carry  <= w_carry_nxt;
                // Publish the result together with the final bit
                if (w_last) begin
                    r_sum <= w_sum_nxt;
                    r_co  <= w_carry_nxt;
                end
            end
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign sum       = r_sum;
    assign co        = r_co;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: scoreboard of expected {co,sum} per accepted operation.
module tb_serial_adder;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a;
    logic [7:0] b;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] sum;
    logic       co;

    int checks   = 0;
    int failures = 0;
    logic [8:0] exp_q[$];

    serial_adder #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .co        (co)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one operation, record its expected result, hold until the accepting edge
    task automatic drive_op(input logic [7:0] ta, input logic [7:0] tb_v);
        int n;
        n = 0;
        while (in_ready !== 1'b1 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 40) begin
            checks++; failures++;
            $display("FAIL drive_op in_ready timeout got=%b exp=1", in_ready);
        end
        a = ta; b = tb_v; in_valid = 1'b1;
        exp_q.push_back({1'b0, ta} + {1'b0, tb_v});
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = 8'hXX; b = 8'hXX;
    endtask

    // Count edges until out_valid is seen; -1 on timeout
    task automatic wait_valid(output int cyc);
        cyc = -1;
        for (int i = 1; i <= 60; i++) begin
            @(posedge clk); #1;
            if (out_valid === 1'b1) begin
                cyc = i;
                break;
            end
        end
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({in_ready, out_valid, co, sum} !== {1'b1, 1'b0, 1'b0, 8'h00}) begin
            failures++;
            $display("FAIL reset in_ready=%b out_valid=%b co=%b sum=%h exp 1 0 0 00",
                     in_ready, out_valid, co, sum);
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_add(input string nm, input logic [7:0] ta, input logic [7:0] tb_v);
        int cyc;
        logic [8:0] exp;
        drive_op(ta, tb_v);
        wait_valid(cyc);
        checks++;
        if (cyc != 8) begin
            failures++;
            $display("FAIL %s latency got=%0d exp=8", nm, cyc);
        end
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 9'h1FF;
        checks++;
        if ({co, sum} !== exp) begin
            failures++;
            $display("FAIL %s result got co=%b sum=%h exp co=%b sum=%h", nm, co, sum, exp[8], exp[7:0]);
        end
        consume();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL %s release out_valid=%b in_ready=%b exp 0 1", nm, out_valid, in_ready);
        end
    endtask

    task automatic test_backpressure();
        int cyc;
        logic [8:0] exp;
        drive_op(8'hAA, 8'h55);
        wait_valid(cyc);
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 9'h1FF;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || {co, sum} !== exp) begin
                failures++;
                $display("FAIL backpressure cyc%0d out_valid=%b in_ready=%b co=%b sum=%h exp 1 0 %b %h",
                         i, out_valid, in_ready, co, sum, exp[8], exp[7:0]);
            end
            @(posedge clk); #1;
        end
        consume();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL backpressure release out_valid=%b in_ready=%b exp 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_busy();
        int cyc;
        logic [8:0] exp;
        drive_op(8'h3C, 8'h0A);
        @(posedge clk); #1;
        a = 8'h01; b = 8'h01; in_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        in_valid = 1'b0;
        wait_valid(cyc);
        checks++;
        if (cyc != 5) begin
            failures++;
            $display("FAIL busy latency got=%0d exp=5", cyc);
        end
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 9'h1FF;
        checks++;
        if ({co, sum} !== exp) begin
            failures++;
            $display("FAIL busy result got co=%b sum=%h exp co=%b sum=%h", co, sum, exp[8], exp[7:0]);
        end
        consume();
        for (int i = 0; i < 12; i++) begin
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                checks++; failures++;
                $display("FAIL busy ghost op out_valid=%b in_ready=%b exp 0 1", out_valid, in_ready);
                break;
            end
            @(posedge clk); #1;
        end
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL busy idle out_valid=%b exp 0", out_valid);
        end
    endtask

    task automatic test_reset_abort();
        drive_op(8'h77, 8'h11);
        void'(exp_q.pop_back());
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({out_valid, in_ready, co, sum} !== {1'b0, 1'b1, 1'b0, 8'h00}) begin
            failures++;
            $display("FAIL reset_abort out_valid=%b in_ready=%b co=%b sum=%h exp 0 1 0 00",
                     out_valid, in_ready, co, sum);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        test_add("after_abort", 8'h24, 8'h81);
    endtask

    task automatic test_back_to_back();
        logic [7:0] ra;
        logic [7:0] rb;
        for (int i = 0; i < 6; i++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            test_add("b2b", ra, rb);
        end
    endtask

    initial begin
        test_reset();
        test_add("add_0f_33", 8'h0F, 8'h33);
        test_add("ripple_ff_01", 8'hFF, 8'h01);
        test_add("max_ff_ff", 8'hFF, 8'hFF);
        test_add("clear_00_00", 8'h00, 8'h00);
        test_backpressure();
        test_busy();
        test_reset_abort();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

endmodule
